// File: rtl/write_merge_buffer_if.sv
// Bus bundle for write_merge_buffer: the CPU-side word write port and the
// cache-line output port.
//   slave  : used by the merge buffer (takes word writes, produces lines)
//   master : used by the producer/consumer side (drives writes, accepts lines)
// Signals:
//   wr_valid/wr_ready         word write handshake
//   wr_addr, wr_data          byte address and write word
//   wr_byte_en                per-byte enable, bit0 = low byte
//   flush_req                 single-cycle request to emit the partial line
//   line_valid/line_ready     line handshake
//   line_addr, line_data      line address and merged line contents
//   line_byte_en              per-byte valid mask of the line
interface write_merge_buffer_if #(
  parameter int WORD_W = 16,
  parameter int LINE_W = 128,
  parameter int ADDR_W = 16
);
  localparam int WBYTES = WORD_W / 8;
  localparam int LBYTES = LINE_W / 8;
  localparam int OFF_W  = $clog2(LBYTES);

  logic                wr_valid;
  logic                wr_ready;
  logic [ADDR_W-1:0]   wr_addr;
  logic [WORD_W-1:0]   wr_data;
  logic [WBYTES-1:0]   wr_byte_en;
  logic                flush_req;
  logic                line_valid;
  logic                line_ready;
  logic [ADDR_W-OFF_W-1:0] line_addr;
  logic [LINE_W-1:0]   line_data;
  logic [LBYTES-1:0]   line_byte_en;

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_byte_en, flush_req, line_ready,
    output wr_ready, line_valid, line_addr, line_data, line_byte_en
  );

  modport master (
    output wr_valid, wr_addr, wr_data, wr_byte_en, flush_req, line_ready,
    input  wr_ready, line_valid, line_addr, line_data, line_byte_en
  );
endinterface

// File: rtl/write_merge_buffer.sv
// Write-combining line buffer. Byte-enabled word writes are merged into one
// line-wide register with a per-byte valid mask; the line is emitted with a
// valid/ready handshake when it fills, when a write targets another line, or
// on an explicit flush.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    write_merge_buffer_if.slave (word write port + line output port)
//   idle   high only while the buffer holds nothing (EMPTY)
module write_merge_buffer #(
  parameter int WORD_W = 16,
  parameter int LINE_W = 128,
  parameter int ADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  write_merge_buffer_if.slave  bus,
  output logic                 idle
);
  localparam int WBYTES = WORD_W / 8;
  localparam int LBYTES = LINE_W / 8;
  localparam int OFF_W  = $clog2(LBYTES);
  localparam int WSH    = $clog2(WBYTES);
  localparam int TAG_W  = ADDR_W - OFF_W;
  localparam int WIDX_W = OFF_W - WSH;

  typedef enum logic [1:0] {EMPTY, FILLING, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [LINE_W-1:0]   data_q, data_d;
  logic [LBYTES-1:0]   mask_q, mask_d;

  logic [TAG_W-1:0]    wr_tag;
  logic [WIDX_W-1:0]   word_idx;
  logic                tag_match;
  logic                accept;

  assign wr_tag    = bus.wr_addr[ADDR_W-1:OFF_W];
  assign word_idx  = bus.wr_addr[OFF_W-1:WSH];
  assign tag_match = (tag_q == wr_tag);

  // A write to a different line is stalled while FILLING; the producer keeps
  // it asserted and it is taken once the current line has drained.
  assign bus.wr_ready = !reset && (state_q != DRAIN) &&
                        !((state_q == FILLING) && !tag_match);
  assign accept       = bus.wr_valid && bus.wr_ready;

  assign bus.line_valid   = (state_q == DRAIN);
  assign bus.line_addr    = tag_q;
  assign bus.line_data    = data_q;
  assign bus.line_byte_en = mask_q;
  assign idle             = (state_q == EMPTY);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can
    // leave it unassigned, which would infer a latch.
    state_d = state_q;
    tag_d   = tag_q;
    data_d  = data_q;
    mask_d  = mask_q;

    // Merge enabled bytes; an all-zero enable in EMPTY changes nothing.
    if (accept) begin
      for (int j = 0; j < WBYTES; j++) begin
        if (bus.wr_byte_en[j]) begin
          data_d[(int'(word_idx) * WBYTES + j) * 8 +: 8] = bus.wr_data[j*8 +: 8];
          mask_d[int'(word_idx) * WBYTES + j]            = 1'b1;
        end
      end
    end

    unique case (state_q)
      EMPTY: begin
        if (accept && (|bus.wr_byte_en)) begin
          tag_d   = wr_tag;
          state_d = FILLING;
        end
      end
      FILLING: begin
        // The full-mask test uses the post-merge mask so a write that
        // completes the line drains it on the following cycle.
        if ((bus.wr_valid && !tag_match) || bus.flush_req || (&mask_d))
          state_d = DRAIN;
      end
      DRAIN: begin
        if (bus.line_ready) begin
          state_d = EMPTY;
          data_d  = '0;
          mask_d  = '0;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: state registers are updated with non-blocking assignments so all
  // of them sample the same pre-edge values.
  // NOTE: the data register is reset too, because line_data is a visible
  // output that must read zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      tag_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end
endmodule

// File: tb/tb_write_merge_buffer.sv
module tb_write_merge_buffer;
  logic clk = 1'b0;
  logic reset;
  logic idle;

  always #5 clk = ~clk;

  write_merge_buffer_if #(.WORD_W(16), .LINE_W(128), .ADDR_W(16)) bus ();

  write_merge_buffer #(.WORD_W(16), .LINE_W(128), .ADDR_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .idle  (idle)
  );

  typedef struct {
    logic         rst;
    logic         vld;
    logic [15:0]  addr;
    logic [15:0]  data;
    logic [1:0]   be;
    logic         flush;
    logic         lrdy;
    logic         e_rdy;
    logic         e_lv;
    logic         e_idle;
    logic         chk_addr;
    logic [11:0]  e_addr;
    logic [15:0]  e_be;
    logic [127:0] e_data;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, vld, input logic [15:0] addr, data,
                              input logic [1:0] be, input logic flush, lrdy,
                              input logic e_rdy, e_lv, e_idle, chk_addr,
                              input logic [11:0] e_addr, input logic [15:0] e_be,
                              input logic [127:0] e_data);
    vec_t v;
    v.rst = rst; v.vld = vld; v.addr = addr; v.data = data; v.be = be;
    v.flush = flush; v.lrdy = lrdy; v.e_rdy = e_rdy; v.e_lv = e_lv;
    v.e_idle = e_idle; v.chk_addr = chk_addr; v.e_addr = e_addr;
    v.e_be = e_be; v.e_data = e_data;
    return v;
  endfunction

  task automatic drive(input logic rst, vld, input logic [15:0] addr, data,
                       input logic [1:0] be, input logic flush, lrdy);
    reset          = rst;
    bus.wr_valid   = vld;
    bus.wr_addr    = addr;
    bus.wr_data    = data;
    bus.wr_byte_en = be;
    bus.flush_req  = flush;
    bus.line_ready = lrdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] model;

    //            rst vld addr     data     be     fl lr  rdy lv idl ca addr    be        data
    vecs.push_back(mk(1, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 0, 0, 1, 1, 12'h000, 16'h0000, 128'h0));
    vecs.push_back(mk(0, 0, 16'h0042, 16'h0000, 2'b00, 0, 0, 1, 0, 1, 0, 12'h000, 16'h0000, 128'h0));
    vecs.push_back(mk(0, 1, 16'h0042, 16'h1234, 2'b11, 0, 0, 1, 0, 1, 0, 12'h000, 16'h0000, 128'h0));
    vecs.push_back(mk(0, 0, 16'h0042, 16'h0000, 2'b00, 1, 0, 1, 0, 0, 1, 12'h004, 16'h000C, 128'h1234_0000));
    vecs.push_back(mk(0, 0, 16'h0042, 16'h0000, 2'b00, 0, 0, 0, 1, 0, 1, 12'h004, 16'h000C, 128'h1234_0000));
    vecs.push_back(mk(0, 0, 16'h0042, 16'h0000, 2'b00, 0, 1, 0, 1, 0, 1, 12'h004, 16'h000C, 128'h1234_0000));
    vecs.push_back(mk(0, 0, 16'h0200, 16'h0000, 2'b00, 0, 0, 1, 0, 1, 0, 12'h000, 16'h0000, 128'h0));
    vecs.push_back(mk(0, 1, 16'h0200, 16'h00AA, 2'b01, 0, 0, 1, 0, 1, 0, 12'h000, 16'h0000, 128'h0));
    vecs.push_back(mk(0, 1, 16'h0200, 16'hBB00, 2'b10, 0, 0, 1, 0, 0, 1, 12'h020, 16'h0001, 128'h00AA));
    vecs.push_back(mk(0, 1, 16'h0200, 16'h1111, 2'b11, 0, 0, 1, 0, 0, 1, 12'h020, 16'h0003, 128'hBBAA));
    vecs.push_back(mk(0, 0, 16'h0200, 16'h0000, 2'b00, 1, 0, 1, 0, 0, 1, 12'h020, 16'h0003, 128'h1111));
    vecs.push_back(mk(0, 0, 16'h0200, 16'h0000, 2'b00, 0, 1, 0, 1, 0, 1, 12'h020, 16'h0003, 128'h1111));
    vecs.push_back(mk(0, 1, 16'h0500, 16'hFFFF, 2'b00, 0, 0, 1, 0, 1, 0, 12'h000, 16'h0000, 128'h0));
    vecs.push_back(mk(0, 0, 16'h0500, 16'h0000, 2'b00, 1, 0, 1, 0, 1, 0, 12'h000, 16'h0000, 128'h0));
    vecs.push_back(mk(0, 0, 16'h0500, 16'h0000, 2'b00, 0, 0, 1, 0, 1, 0, 12'h000, 16'h0000, 128'h0));

    drive(1, 0, 16'h0, 16'h0, 2'b00, 0, 0);
    step();

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].addr, vecs[i].data, vecs[i].be,
            vecs[i].flush, vecs[i].lrdy);
      #1;
      check($sformatf("v%0d wr_ready", i), 128'(bus.wr_ready), 128'(vecs[i].e_rdy));
      check($sformatf("v%0d line_valid", i), 128'(bus.line_valid), 128'(vecs[i].e_lv));
      check($sformatf("v%0d idle", i), 128'(idle), 128'(vecs[i].e_idle));
      check($sformatf("v%0d line_byte_en", i), 128'(bus.line_byte_en), 128'(vecs[i].e_be));
      check($sformatf("v%0d line_data", i), bus.line_data, vecs[i].e_data);
      if (vecs[i].chk_addr)
        check($sformatf("v%0d line_addr", i), 128'(bus.line_addr), 128'(vecs[i].e_addr));
      step();
    end

    // Eight full-word writes fill line 0x010 and drain without a flush.
    model = '0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 16'h0100 + 16'(2 * i), 16'hA000 + 16'(i), 2'b11, 0, 0);
      model[i*16 +: 16] = 16'hA000 + 16'(i);
      #1;
      check($sformatf("fill%0d wr_ready", i), 128'(bus.wr_ready), 128'(1'b1));
      check($sformatf("fill%0d line_valid", i), 128'(bus.line_valid), 128'(1'b0));
      step();
    end
    drive(0, 0, 16'h0100, 16'h0, 2'b00, 0, 0);
    #1;
    check("fill line_valid", 128'(bus.line_valid), 128'(1'b1));
    check("fill line_byte_en", 128'(bus.line_byte_en), 128'hFFFF);
    check("fill line_addr", 128'(bus.line_addr), 128'h010);
    check("fill line_data", bus.line_data, model);
    bus.line_ready = 1'b1;
    step();
    bus.line_ready = 1'b0;
    #1;
    check("fill idle after drain", 128'(idle), 128'(1'b1));
    check("fill line_valid after drain", 128'(bus.line_valid), 128'(1'b0));

    // Tag change while FILLING: stall, drain with back-pressure, then accept.
    drive(0, 1, 16'h0200, 16'h5555, 2'b11, 0, 0);
    step();
    drive(0, 1, 16'h0300, 16'h7777, 2'b11, 0, 0);
    #1;
    check("miss wr_ready", 128'(bus.wr_ready), 128'(1'b0));
    check("miss line_valid", 128'(bus.line_valid), 128'(1'b0));
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.line_ready = 1'b1;
      #1;
      check($sformatf("hold%0d line_valid", i), 128'(bus.line_valid), 128'(1'b1));
      check($sformatf("hold%0d line_addr", i), 128'(bus.line_addr), 128'h020);
      check($sformatf("hold%0d line_byte_en", i), 128'(bus.line_byte_en), 128'h0003);
      check($sformatf("hold%0d line_data", i), bus.line_data, 128'h5555);
      check($sformatf("hold%0d wr_ready", i), 128'(bus.wr_ready), 128'(1'b0));
      step();
    end
    bus.line_ready = 1'b0;
    #1;
    check("post-drain idle", 128'(idle), 128'(1'b1));
    check("post-drain wr_ready", 128'(bus.wr_ready), 128'(1'b1));
    check("post-drain line_valid", 128'(bus.line_valid), 128'(1'b0));
    step();
    bus.wr_valid = 1'b0;
    #1;
    check("held write idle", 128'(idle), 128'(1'b0));
    check("held write line_addr", 128'(bus.line_addr), 128'h030);
    check("held write line_byte_en", 128'(bus.line_byte_en), 128'h0003);
    check("held write line_data", bus.line_data, 128'h7777);

    // Reset in the middle of DRAIN discards the line.
    bus.flush_req = 1'b1;
    step();
    bus.flush_req = 1'b0;
    #1;
    check("pre-reset line_valid", 128'(bus.line_valid), 128'(1'b1));
    reset = 1'b1;
    #1;
    check("in-reset wr_ready", 128'(bus.wr_ready), 128'(1'b0));
    step();
    check("reset line_valid", 128'(bus.line_valid), 128'(1'b0));
    check("reset line_byte_en", 128'(bus.line_byte_en), 128'h0);
    check("reset line_data", bus.line_data, 128'h0);
    check("reset line_addr", 128'(bus.line_addr), 128'h0);
    check("reset idle", 128'(idle), 128'(1'b1));
    reset = 1'b0;
    bus.flush_req = 1'b1;
    step();
    bus.flush_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("empty flush%0d line_valid", i), 128'(bus.line_valid), 128'(1'b0));
      check($sformatf("empty flush%0d idle", i), 128'(idle), 128'(1'b1));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
